// File: rtl/bandas_pkg.sv
// Shared definitions for the band FIFO bank: default geometry and band word type.
package bandas_pkg;
   localparam int WIDTH_DEF = 25;
   localparam int DEPTH_DEF = 8;

   typedef logic [WIDTH_DEF-1:0] banda_t;
endpackage

// File: rtl/banco_bandas_mem.sv
// DEPTH x WIDTH band storage: one synchronous write port, combinational read at the head.
module mem_bandas
   import bandas_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/banco_bandas.sv
// Band FIFO bank: pointers, occupancy counter, sticky error and rotate-to-tail mode.
module banco_bandas
   import bandas_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             escribir,
   input  logic             leer,
   input  logic             rotar,
   output logic [WIDTH-1:0] out,
   output logic             valido,
   output logic             lleno,
   output logic             vacio,
   output logic [AW:0]      cuenta,
   output logic             error
);

   localparam logic [AW:0] CUENTA_LLENA = (AW+1)'(DEPTH);

   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [WIDTH-1:0] cabeza;
   logic             rd_ok;
   logic             wr_ok;
   logic             rot_ok;
   logic             ilegal;
   logic             mem_we;
   logic [WIDTH-1:0] mem_wdata;

   // Flags come straight from the registered counter, so they cannot glitch.
   assign lleno = (cuenta == CUENTA_LLENA);
   assign vacio = (cuenta == '0);

   mem_bandas #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (mem_wdata),
      .raddr (rd_ptr),
      .rdata (cabeza)
   );

   // Accept/reject decisions for this cycle's strobes.
   always_comb begin
      rd_ok  = leer && !vacio;
      wr_ok  = escribir && (!lleno || rd_ok);
      rot_ok = rotar && !leer && !escribir && !vacio;
      ilegal = (escribir && lleno && !rd_ok)
             || (leer && vacio)
             || (rotar && (leer || escribir))
             || (rotar && vacio);
      mem_we = wr_ok || rot_ok;
      if (rot_ok) begin
         mem_wdata = cabeza;
      end else begin
         mem_wdata = in;
      end
   end

   // Pointer, counter, output and error state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cuenta <= '0;
         out    <= '0;
         valido <= 1'b0;
         error  <= 1'b0;
      end else begin
         valido <= rd_ok || rot_ok;
         if (rd_ok || rot_ok) begin
            out    <= cabeza;
            rd_ptr <= rd_ptr + AW'(1);
         end
         // A full-bank rotate rewrites the head slot in place: both pointers move together.
         if (wr_ok || rot_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   cuenta <= cuenta + (AW+1)'(1);
            2'b01:   cuenta <= cuenta - (AW+1)'(1);
            default: cuenta <= cuenta;
         endcase
         if (ilegal) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: doc/banco_bandas.md
# banco_bandas

Parametrised FIFO bank of band words, the successor to the single-entry band register. Holds up to DEPTH words of WIDTH bits, written and read with the same `escribir`/`leer` strobes, and adds occupancy flags, a sticky error flag and a rotate mode. Rotate recirculates the head word to the tail so a sequence of bands can scroll continuously. It sits between the band generator and the display/output stage.

## Interface
- WIDTH, 25, bits per band word.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  WIDTH  band word to write.
- escribir  in  1  write strobe, sampled each cycle.
- leer  in  1  read strobe, sampled each cycle.
- rotar  in  1  rotate strobe: pop the head and push it to the tail.
- out  out  WIDTH  last word read or rotated (registered).
- valido  out  1  one-cycle pulse when `out` was updated this cycle.
- lleno  out  1  cuenta == DEPTH.
- vacio  out  1  cuenta == 0.
- cuenta  out  AW+1  number of stored words, 0..DEPTH.
- error  out  1  sticky illegal-operation flag.

## Operation
- Accepted-read condition: rd_ok = leer && !vacio.
- Accepted-write condition: wr_ok = escribir && (!lleno || rd_ok). Writing while full is legal when a read is accepted in the same cycle.
- rd_ok: `out` <= mem[rd_ptr], rd_ptr increments, valido=1.
- wr_ok: mem[wr_ptr] <= in, wr_ptr increments.
- cuenta: +1 on write only, -1 on read only, unchanged on both.
- Rotate condition: rot_ok = rotar && !leer && !escribir && !vacio.
  - mem[wr_ptr] <= mem[rd_ptr], `out` <= mem[rd_ptr], both pointers increment, valido=1, cuenta unchanged.
  - With cuenta==DEPTH this is a pure pointer advance, and the written slot equals the read slot.
- Illegal operations set `error` (sticky, cleared only by reset):
  - escribir while lleno without rd_ok; the write is dropped.
  - leer while vacio; nothing is popped, and a simultaneous write still succeeds with no fall-through.
  - rotar together with leer or escribir; rotate is ignored and the read/write proceeds normally.
  - rotar while vacio.
- Pointers wrap modulo DEPTH naturally because of the power-of-2 depth.
- `out` holds its value when no read or rotate occurs, and valido=0.
- Memory contents are not cleared by reset.

## Timing
- Reset values: out=0, valido=0, lleno=0, vacio=1, cuenta=0, error=0, both pointers=0.
- Reset has priority over every strobe in the same cycle. Reset mid-stream discards all stored words in one cycle.
- Read latency is 1 cycle: leer sampled at edge N, `out`/valido valid after edge N.
- Write-to-read latency: a word written at edge N is readable with leer at edge N+1. Flags update at edge N.
- lleno, vacio and cuenta are registered (or derived from registered cuenta) and glitch-free.
- Sustained throughput is one read and one write per cycle at any occupancy, including full and empty (write side only when empty).

## Structure
- Shared package `bandas_pkg`:
  - default WIDTH (25) and DEPTH (8) constants;
  - typedef for the band word.
- One natural sub-module: `mem_bandas`, a DEPTH x WIDTH register array with one write port and a combinational read port at rd_ptr.
- Pointers, counter, flags and the `out` register live in `banco_bandas`.

## Test plan
All scenarios use WIDTH=25, DEPTH=4.
- Reset then idle: out=0, cuenta=0, vacio=1, lleno=0, error=0 for 5 cycles.
- Fill and drain:
  - Write 0x0F83E0, 0x1F07C1F, 0x1FF801F, 0x003FFE0, which gives lleno=1 and cuenta=4.
  - A 5th write sets error=1 and cuenta stays 4.
  - Four reads return the words in order, each with one valido pulse, ending with vacio=1.
- Simultaneous read and write while full: with lleno=1, leer and escribir (0x1555555) together give out=oldest word, cuenta=4, error=0. The last read after draining returns 0x1555555.
- Rotate:
  - With 0x1998CCC9, wait, use three words A=0x1998CC9, B=0x0667336, C=0x1C71C71.
  - rotar x3 gives out=A,B,C and cuenta=3.
  - Subsequent reads return A,B,C; error=0.
- Illegal ops:
  - leer when empty sets error=1, cuenta=0, out unchanged.
  - rotar together with escribir means the write is taken, no rotate, error=1.
- Reset mid-operation: with cuenta=3, assert reset for 1 cycle. All outputs return to reset values, and a following read sets error without changing out.
